// File: rtl/iq_pkg.sv
// Shared I/Q sample widths, RX FIFO sizing and SEND PARAMS status-bit layout.
// No logic; constants and a small helper only.
// Imported by the RX FIFO and by whatever assembles the status byte.
package iq_pkg;

  localparam int IQ_W              = 16;
  localparam int RX_FIFO_ADDR_W    = 6;
  localparam int RX_FIFO_AFULL_LVL = 48;

  // Bit positions of the sticky RX FIFO flags inside the SEND PARAMS status byte.
  localparam int STAT_RX_OVF_BIT   = 6;
  localparam int STAT_RX_UDF_BIT   = 7;

  // Places the two sticky flags at their status-byte positions, other bits zero.
  function automatic logic [7:0] rx_fifo_status(input logic ovf, input logic udf);
    logic [7:0] s;
    s                  = '0;
    s[STAT_RX_OVF_BIT] = ovf;
    s[STAT_RX_UDF_BIT] = udf;
    return s;
  endfunction

endpackage

// File: rtl/iq_dpram.sv
// Simple dual-port RAM: one write port, one registered read port (block RAM style).
// Read data appears 1 clk after rd_en and holds until the next rd_en.
// No backpressure; the caller guarantees address validity.
module iq_dpram #(
  parameter int ADDR_W = 6,
  parameter int WIDTH  = 32
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_dat
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rd_dat_q;

  // Write port; contents are never cleared, only overwritten.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wr_addr] <= wr_dat;
  end

  // Registered read port; read-before-write when both ports hit one address.
  always_ff @(posedge clk_in) begin
    if (rst)        rd_dat_q <= '0;
    else if (rd_en) rd_dat_q <= mem_q[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/rx_iq_fifo.sv
// RX I/Q pair FIFO between the DDC output and the MCU parallel-bus reader.
// Pop data/out_valid exactly 1 clk after rd_req; output word holds between pops.
// No stall: writes while full are dropped (overflow), reads while empty ignored (underflow).
module rx_iq_fifo
  import iq_pkg::*;
#(
  parameter int DATA_W    = IQ_W,
  parameter int ADDR_W    = RX_FIFO_ADDR_W,
  parameter int AFULL_LVL = RX_FIFO_AFULL_LVL
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_I,
  input  logic signed [DATA_W-1:0] in_Q,
  input  logic                     in_valid,
  input  logic                     rd_req,
  output logic signed [DATA_W-1:0] out_I,
  output logic signed [DATA_W-1:0] out_Q,
  output logic                     out_valid,
  output logic [ADDR_W:0]          level,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_flags
);

  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AFULL_TH = AFULL_LVL[ADDR_W:0];

  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic                out_vld_q;
  logic                ptr_full, ptr_empty;
  logic                wr_fire, rd_fire;
  logic [2*DATA_W-1:0] rd_dat;

  // Wrap bit differs with equal low bits means full; all bits equal means empty.
  assign ptr_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign ptr_empty = (wr_ptr_q == rd_ptr_q);

  // A same-cycle pop frees a slot, so a write into a full FIFO is still taken.
  // A write into an empty FIFO never falls through to a same-cycle read.
  assign rd_fire = rd_req && !ptr_empty;
  assign wr_fire = in_valid && (!ptr_full || rd_fire);

  // Next-state for pointers, fill level and sticky flags (a new event beats clr_flags).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + ONE;
    if (rd_fire) rd_ptr_d = rd_ptr_q + ONE;
    case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase
    if (clr_flags) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (in_valid && !wr_fire) ovf_d = 1'b1;
    if (rd_req && !rd_fire)   udf_d = 1'b1;
  end

  // State registers; reset drops contents and any pending pop.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      out_vld_q <= rd_fire;
    end
  end

  iq_dpram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (2*DATA_W)
  ) u_ram (
    .clk_in  (clk_in),
    .rst     (rst),
    .wr_en   (wr_fire && !rst),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_dat  ({in_Q, in_I}),
    .rd_en   (rd_fire && !rst),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_dat  (rd_dat)
  );

  assign out_I       = rd_dat[DATA_W-1:0];
  assign out_Q       = rd_dat[2*DATA_W-1:DATA_W];
  assign out_valid   = out_vld_q;
  assign level       = level_q;
  assign empty       = (level_q == '0);
  assign almost_full = (level_q >= AFULL_TH);
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule

// File: tb/tb_rx_iq_fifo.sv
// Randomised and directed stimulus against a queue-based FIFO model with a scoreboard.
// Popped pairs must appear exactly one clock after the accepted rd_req.
// Status outputs are compared every cycle.
module tb_rx_iq_fifo;

  localparam int DEPTH = 64;
  localparam int AFULL = 48;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_I = '0, in_Q = '0;
  logic        in_valid = 1'b0, rd_req = 1'b0, clr_flags = 1'b0;
  logic [15:0] out_I, out_Q;
  logic        out_valid, empty, almost_full, overflow, underflow;
  logic [6:0]  level;

  always #5 clk_in = ~clk_in;

  rx_iq_fifo dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .in_I        (in_I),
    .in_Q        (in_Q),
    .in_valid    (in_valid),
    .rd_req      (rd_req),
    .out_I       (out_I),
    .out_Q       (out_Q),
    .out_valid   (out_valid),
    .level       (level),
    .empty       (empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_flags   (clr_flags)
  );

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_q[$];
  bit          m_ovf, m_udf;
  logic [15:0] hold_i = '0, hold_q = '0;
  int          vecs = 0, errs = 0;
  int          cyc = 0;
  bit          mon_on = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, apply the FIFO rules to the model at the edge, compare status.
  task automatic step(input bit iv, input logic [15:0] i, input logic [15:0] q,
                      input bit rr, input bit clr, input bit r);
    bit          rf, wok;
    logic [31:0] p;
    in_valid = iv; in_I = i; in_Q = q; rd_req = rr; clr_flags = clr; rst = r;
    @(posedge clk_in);
    #1;
    if (r) begin
      model_q.delete();
      sb_q.delete();
      m_ovf = 0; m_udf = 0;
      hold_i = '0; hold_q = '0;
    end else begin
      rf  = rr && (model_q.size() > 0);
      wok = iv && ((model_q.size() < DEPTH) || rf);
      if (rf) begin
        p = model_q.pop_front();
        sb_q.push_back('{p[15:0], p[31:16], cyc});
      end
      if (wok) model_q.push_back({q, i});
      m_ovf = (iv && !wok) || (m_ovf && !clr);
      m_udf = (rr && !rf)  || (m_udf && !clr);
    end
    @(negedge clk_in);
    chk("level",       int'(level),       model_q.size());
    chk("empty",       int'(empty),       int'(model_q.size() == 0));
    chk("almost_full", int'(almost_full), int'(model_q.size() >= AFULL));
    chk("overflow",    int'(overflow),    int'(m_ovf));
    chk("underflow",   int'(underflow),   int'(m_udf));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pair.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (mon_on) begin
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
          e = sb_q.pop_front();
          vecs++; errs++;
          $display("FAIL rd_latency: no out_valid for pair I=%0d Q=%0d due cycle %0d, now %0d",
                   e.i, e.q, e.cyc, cyc);
        end
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            vecs++; errs++;
            $display("FAIL spurious_out_valid: got I=%0d Q=%0d, expected no output", out_I, out_Q);
          end else begin
            e = sb_q.pop_front();
            chk("out_I",     int'(out_I), int'(e.i));
            chk("out_Q",     int'(out_Q), int'(e.q));
            chk("out_cycle", cyc,         e.cyc);
            hold_i = e.i; hold_q = e.q;
          end
        end else begin
          chk("hold_I", int'(out_I), int'(hold_i));
          chk("hold_Q", int'(out_Q), int'(hold_q));
        end
      end
    end
  end

  initial begin
    logic [15:0] k;
    // Reset
    step(0, 0, 0, 0, 0, 1);
    mon_on = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // Three writes, three reads
    for (int n = 1; n <= 3; n++) begin
      k = 16'(n);
      step(1, k, -k, 0, 0, 0);
    end
    for (int n = 0; n < 3; n++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Fill to 64, 65th dropped, then full with simultaneous read+write
    for (int n = 1; n <= 65; n++) begin
      k = 16'(n + 100);
      step(1, k, ~k, 0, 0, 0);
    end
    step(1, 16'h0BAD, 16'h0BAD, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);

    // Drain, then pop I=7, then read on empty; clear underflow
    while (model_q.size() > 0) step(0, 0, 0, 1, 0, 0);
    step(1, 16'd7, 16'hFFF9, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    // Write and read on empty in the same cycle
    step(1, 16'd9, 16'd90, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);

    // Steady state at level 2 for 200 cycles so pointers wrap
    step(1, 16'd500, 16'd501, 0, 0, 0);
    step(1, 16'd502, 16'd503, 0, 0, 0);
    for (int n = 0; n < 200; n++) begin
      k = 16'(1000 + n);
      step(1, k, k ^ 16'h5A5A, 1, 0, 0);
    end

    // Reset with level 20 and a pending read, then new data
    while (model_q.size() < 20) step(1, 16'($urandom), 16'($urandom), 0, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    step(1, 16'h1234, 16'h8765, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Random phases alternating write-heavy and read-heavy traffic
    for (int ph = 0; ph < 8; ph++) begin
      int pw, pr;
      pw = (ph % 2 == 0) ? 85 : 30;
      pr = (ph % 2 == 0) ? 30 : 85;
      for (int n = 0; n < 350; n++) begin
        step($urandom_range(0, 99) < pw, 16'($urandom), 16'($urandom),
             $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 5,
             $urandom_range(0, 999) < 3);
      end
    end

    for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
